// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, centre sampling, byte strobe plus framing/overrun flags.
// Optional UART_RX_MAJORITY_EN: 2-of-3 majority vote around each bit centre (adds one cycle of latency).
`timescale 1ns/1ps
module uart_rx #(
  parameter int CLK_PER_HALF_BIT = 435
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  input  logic       rx_ack,
  output logic [7:0] rdata,
  output logic       rx_ready,
  output logic       ferr,
  output logic       ovr
);

  localparam logic [31:0] BIT_PT   = 32'(2 * CLK_PER_HALF_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [31:0] START_PT = 32'(CLK_PER_HALF_BIT);
`else
  localparam logic [31:0] START_PT = 32'(CLK_PER_HALF_BIT - 1);
`endif

  typedef enum logic [2:0] {
    s_idle, s_start, s_data, s_stop, s_break
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rx_ready_q, rx_ready_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;
  logic        pending_q, pending_d;
  logic        sync1_q, sync2_q, prev_q;
  logic        rxd_s, samp, done;

  assign rxd_s = sync2_q;

`ifdef UART_RX_MAJORITY_EN
  logic hist2_q;
  // prev_q and hist2_q hold rxd_s one and two cycles back, so the vote spans centre-1..centre+1.
  assign samp = (rxd_s & prev_q) | (rxd_s & hist2_q) | (prev_q & hist2_q);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) hist2_q <= 1'b1;
    else       hist2_q <= prev_q;
  end
`else
  assign samp = rxd_s;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      state_q    <= s_idle;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      rdata_q    <= '0;
      rx_ready_q <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      sync1_q    <= rxd;
      sync2_q    <= sync1_q;
      prev_q     <= rxd_s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      rdata_q    <= rdata_d;
      rx_ready_q <= rx_ready_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
      pending_q  <= pending_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 32'd1;
    idx_d      = idx_q;
    shift_d    = shift_q;
    rdata_d    = rdata_q;
    rx_ready_d = 1'b0;
    ferr_d     = 1'b0;
    done       = 1'b0;
    case (state_q)
      s_idle: begin
        cnt_d = '0;
        if (prev_q && !rxd_s) state_d = s_start;
      end
      s_start: begin
        if (cnt_q == START_PT) begin
          cnt_d = '0;
          idx_d = '0;
          state_d = samp ? s_idle : s_data;
        end
      end
      s_data: begin
        if (cnt_q == BIT_PT) begin
          cnt_d   = '0;
          shift_d = {samp, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = s_stop;
        end
      end
      s_stop: begin
        if (cnt_q == BIT_PT) begin
          cnt_d = '0;
          if (samp) begin
            // Back to idle mid stop bit so a back-to-back start edge is not missed.
            rdata_d    = shift_q;
            rx_ready_d = 1'b1;
            done       = 1'b1;
            state_d    = s_idle;
          end else begin
            ferr_d  = 1'b1;
            state_d = s_break;
          end
        end
      end
      s_break: begin
        cnt_d = '0;
        if (rxd_s) state_d = s_idle;
      end
      default: begin
        cnt_d   = '0;
        state_d = s_idle;
      end
    endcase
  end

  // An ack seen while rx_ready is high belongs to the previous byte: the new one stays pending.
  always_comb begin
    pending_d = pending_q;
    ovr_d     = ovr_q;
    if (done) begin
      pending_d = 1'b1;
      if (pending_q && !rx_ack) ovr_d = 1'b1;
      else if (rx_ack)          ovr_d = 1'b0;
    end else if (rx_ack) begin
      ovr_d = 1'b0;
      if (!rx_ready_q) pending_d = 1'b0;
    end
  end

  assign rdata    = rdata_q;
  assign rx_ready = rx_ready_q;
  assign ferr     = ferr_q;
  assign ovr      = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at CLK_PER_HALF_BIT=8: directed scenarios plus random frames checked
// against a frame-level model of bytes, framing errors, pending and overrun.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int H = 8;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rdata;
  logic       rx_ready, ferr, ovr;

  uart_rx #(.CLK_PER_HALF_BIT(H)) dut (
    .clk(clk), .rstn(rstn), .rxd(rxd), .rx_ack(rx_ack),
    .rdata(rdata), .rx_ready(rx_ready), .ferr(ferr), .ovr(ovr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed strobes, sampled on the falling edge.
  int         rdy_seen = 0, ferr_seen = 0, last_rdy_cyc = 0;
  logic [7:0] got_q[$];
  always @(negedge clk) begin
    if (rx_ready === 1'b1) begin
      rdy_seen++;
      last_rdy_cyc = cyc;
      got_q.push_back(rdata);
    end
    if (ferr === 1'b1) ferr_seen++;
  end

  // Frame-level reference model.
  int         m_rdy = 0, m_ferr = 0;
  logic [7:0] m_rdata = 8'h00;
  bit         m_pend = 0, m_ovr = 0;
  logic [7:0] exp_q[$];

  int total = 0, bad = 0;
  int start_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_frame(input logic [7:0] b, input bit stop_ok, input bit ack_at_rdy);
    if (stop_ok) begin
      if (m_pend) m_ovr = 1;
      m_pend = 1;
      m_rdata = b;
      m_rdy++;
      exp_q.push_back(b);
      if (ack_at_rdy) m_ovr = 0;
    end else begin
      m_ferr++;
    end
  endtask

  task automatic model_ack();
    m_pend = 0;
    m_ovr = 0;
  endtask

  task automatic drive(input logic v, input int n);
    rxd = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    @(posedge clk);
    #1;
    rx_ack = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_len, input bit ack_at_rdy);
    start_cyc = cyc;
    drive(1'b0, 2 * H);
    for (int i = 0; i < 8; i++) drive(b[i], 2 * H);
    if (ack_at_rdy) begin
      // rx_ack raised for exactly the cycle in which rx_ready is high.
      drive(1'b1, H + 3 + MAJ);
      rx_ack = 1'b1;
      drive(1'b1, 1);
      rx_ack = 1'b0;
      drive(1'b1, H - 4 - MAJ);
    end else begin
      drive(stop, stop_len);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_rdy_cnt"}, 32'(rdy_seen), 32'(m_rdy));
    check({tag, "_ferr_cnt"}, 32'(ferr_seen), 32'(m_ferr));
    check({tag, "_rdata"}, 32'(rdata), 32'(m_rdata));
    check({tag, "_ovr"}, 32'(ovr), 32'(m_ovr));
  endtask

  initial begin
    logic [7:0] b;
    bit         ok, ak;

    repeat (3) @(posedge clk);
    #1;
    check("reset_rdata", 32'(rdata), 32'h0);
    check("reset_rx_ready", 32'(rx_ready), 32'h0);
    check("reset_ferr", 32'(ferr), 32'h0);
    check("reset_ovr", 32'(ovr), 32'h0);
    rstn = 1'b1;
    drive(1'b1, 4 * H);

    // Single frame and its latency.
    send_frame(8'h55, 1'b1, 2 * H, 1'b0);
    model_frame(8'h55, 1'b1, 1'b0);
    check("lat_0x55", 32'(last_rdy_cyc - start_cyc), 32'(19 * H + 3 + MAJ));
    check_state("f55");
    ack_pulse(); model_ack();
    drive(1'b1, 2 * H);

    // Back-to-back: stop bit cut to just over half a bit.
    send_frame(8'hA3, 1'b1, H + 2, 1'b0);
    model_frame(8'hA3, 1'b1, 1'b0);
    send_frame(8'h00, 1'b1, 2 * H, 1'b0);
    model_frame(8'h00, 1'b1, 1'b0);
    check_state("b2b");
    ack_pulse(); model_ack();
    drive(1'b1, 2 * H);

    // Short glitch is rejected, then a normal frame still lands.
    drive(1'b0, 3);
    drive(1'b1, 2 * H);
    check("glitch_rdy_cnt", 32'(rdy_seen), 32'(m_rdy));
    check("glitch_ferr_cnt", 32'(ferr_seen), 32'(m_ferr));
    b = 8'($urandom);
    send_frame(b, 1'b1, 2 * H, 1'b0);
    model_frame(b, 1'b1, 1'b0);
    check_state("post_glitch");
    ack_pulse(); model_ack();
    drive(1'b1, 2 * H);

    // Framing error with a held break, then recovery.
    send_frame(8'h7E, 1'b0, 40, 1'b0);
    model_frame(8'h7E, 1'b0, 1'b0);
    check_state("break");
    drive(1'b1, 2 * H);
    send_frame(8'h12, 1'b1, 2 * H, 1'b0);
    model_frame(8'h12, 1'b1, 1'b0);
    check_state("after_break");
    ack_pulse(); model_ack();
    drive(1'b1, 2 * H);

    // Overrun when the consumer never acknowledges.
    send_frame(8'h11, 1'b1, 2 * H, 1'b0);
    model_frame(8'h11, 1'b1, 1'b0);
    check_state("ovr_first");
    send_frame(8'h22, 1'b1, 2 * H, 1'b0);
    model_frame(8'h22, 1'b1, 1'b0);
    check_state("ovr_second");
    ack_pulse(); model_ack();
    check("ovr_cleared", 32'(ovr), 32'(m_ovr));
    drive(1'b1, 2 * H);

    // Ack coinciding with rx_ready keeps the new byte pending.
    send_frame(8'h5A, 1'b1, 2 * H, 1'b0);
    model_frame(8'h5A, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 0, 1'b1);
    model_frame(8'hC3, 1'b1, 1'b1);
    check_state("ack_at_rdy");
    send_frame(8'h96, 1'b1, 2 * H, 1'b0);
    model_frame(8'h96, 1'b1, 1'b0);
    check_state("still_pending");
    ack_pulse(); model_ack();
    drive(1'b1, 2 * H);

    // Reset in the middle of bit 4 of 0xF0 discards the partial frame.
    drive(1'b0, 2 * H);
    for (int i = 0; i < 4; i++) drive(((8'hF0 >> i) & 8'h01) != 8'h00, 2 * H);
    drive(1'b1, H);
    rstn = 1'b0;
    drive(1'b1, 4);
    m_rdata = 8'h00; m_pend = 0; m_ovr = 0;
    check("rst_mid_rdata", 32'(rdata), 32'h0);
    rstn = 1'b1;
    drive(1'b1, 4 * H);
    check_state("rst_mid");
    send_frame(8'h3C, 1'b1, 2 * H, 1'b0);
    model_frame(8'h3C, 1'b1, 1'b0);
    check_state("after_rst");

    // Random frames, random stop errors, random acknowledgement.
    for (int n = 0; n < 8; n++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      send_frame(b, ok, 2 * H, 1'b0);
      model_frame(b, ok, 1'b0);
      drive(1'b1, $urandom_range(2, 3 * H));
      check_state("rand");
      ak = ($urandom_range(0, 1) == 1);
      if (ak) begin
        ack_pulse(); model_ack();
      end
    end

    check("byte_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check("byte_seq", 32'(got_q[i]), 32'(exp_q[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
